// File: rtl/sprite_motion_ctrl.sv
// rtl/sprite_motion_ctrl.sv - sprite position FSM with speed divider, playfield clamp and grid glide
// Steps a sprite one pixel per tick toward the held direction; optional glide to grid on release.
module sprite_motion_ctrl #(
   parameter int CW       = 10,
   parameter int SPR_W    = 16,
   parameter int SPR_H    = 16,
   parameter int START_X  = 144,
   parameter int START_Y  = 400,
   parameter int MIN_X    = 0,
   parameter int MAX_X    = 640,
   parameter int MIN_Y    = 16,
   parameter int MAX_Y    = 480,
   parameter int STEP_DIV = 1,
   parameter int DW       = 20,
   parameter int GRID     = 16,
   parameter int ALIGN_EN = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          L,
   input  logic          R,
   input  logic          U,
   input  logic          D,
   input  logic [3:0]    blocked,
   input  logic          game_over,
   input  logic [CW-1:0] v_x,
   input  logic [CW-1:0] v_y,
   output logic [CW-1:0] b_x,
   output logic [CW-1:0] b_y,
   output logic [CW-1:0] col,
   output logic [CW-1:0] row,
   output logic          sprite_on,
   output logic [1:0]    facing,
   output logic          moving
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_MOVE  = 2'd1;
   localparam logic [1:0] S_ALIGN = 2'd2;

   // Clamp bounds carry one extra bit so a step below zero cannot wrap into range.
   localparam logic [CW:0]   X_LO     = (CW+1)'(MIN_X);
   localparam logic [CW:0]   X_HI     = (CW+1)'(MAX_X - SPR_W);
   localparam logic [CW:0]   Y_LO     = (CW+1)'(MIN_Y);
   localparam logic [CW:0]   Y_HI     = (CW+1)'(MAX_Y - SPR_H);
   localparam logic [CW:0]   W_M1     = (CW+1)'(SPR_W - 1);
   localparam logic [CW:0]   H_M1     = (CW+1)'(SPR_H - 1);
   localparam logic [CW-1:0] G_MASK   = CW'(GRID - 1);
   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic [DW-1:0] CNT_LAST = DW'(STEP_DIV - 1);

   logic [1:0]    state_q, state_d;
   logic [1:0]    facing_q, facing_d;
   logic [CW-1:0] b_x_q, b_x_d, b_y_q, b_y_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic          moving_q, moving_d;

   logic [3:0]    req;
   logic          held, tick, room, step_ok, cur_aligned, cand_aligned;
   logic [CW-1:0] cand_x, cand_y;
   logic [CW:0]   vx1, vy1, bx1, by1;

   assign req  = {D, U, R, L};
   assign held = req[facing_q];
   assign tick = (state_q != S_IDLE) && (cnt_q == CNT_LAST);

   always_comb begin
      room   = 1'b0;
      cand_x = b_x_q;
      cand_y = b_y_q;
      case (facing_q)
         2'b00: begin room = {1'b0, b_x_q} > X_LO; cand_x = b_x_q - ONE; end
         2'b01: begin room = {1'b0, b_x_q} < X_HI; cand_x = b_x_q + ONE; end
         2'b10: begin room = {1'b0, b_y_q} > Y_LO; cand_y = b_y_q - ONE; end
         default: begin room = {1'b0, b_y_q} < Y_HI; cand_y = b_y_q + ONE; end
      endcase
      // blocked is ordered {left,right,up,down}, the reverse of the facing code.
      step_ok = room && !blocked[~facing_q];
   end

   assign cur_aligned  = ((facing_q[1] ? b_y_q  : b_x_q)  & G_MASK) == '0;
   assign cand_aligned = ((facing_q[1] ? cand_y : cand_x) & G_MASK) == '0;

   always_comb begin
      state_d  = state_q;
      facing_d = facing_q;
      b_x_d    = b_x_q;
      b_y_d    = b_y_q;
      if (game_over) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if      (L) begin facing_d = 2'b00; state_d = S_MOVE; end
               else if (R) begin facing_d = 2'b01; state_d = S_MOVE; end
               else if (U) begin facing_d = 2'b10; state_d = S_MOVE; end
               else if (D) begin facing_d = 2'b11; state_d = S_MOVE; end
            end
            S_MOVE: begin
               if (held) begin
                  if (tick && step_ok) begin
                     b_x_d = cand_x;
                     b_y_d = cand_y;
                  end
               end else begin
                  state_d = ((ALIGN_EN != 0) && !cur_aligned) ? S_ALIGN : S_IDLE;
               end
            end
            S_ALIGN: begin
               if (held) begin
                  state_d = S_MOVE;
               end else if (tick) begin
                  if (step_ok) begin
                     b_x_d = cand_x;
                     b_y_d = cand_y;
                     if (cand_aligned) state_d = S_IDLE;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      if (state_d == S_IDLE || state_q == S_IDLE) cnt_d = '0;
      else if (tick)                              cnt_d = '0;
      else                                        cnt_d = cnt_q + DW'(1);
      moving_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         facing_q <= 2'b11;
         b_x_q    <= CW'(START_X);
         b_y_q    <= CW'(START_Y);
         cnt_q    <= '0;
         moving_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         facing_q <= facing_d;
         b_x_q    <= b_x_d;
         b_y_q    <= b_y_d;
         cnt_q    <= cnt_d;
         moving_q <= moving_d;
      end
   end

   assign vx1 = {1'b0, v_x};
   assign vy1 = {1'b0, v_y};
   assign bx1 = {1'b0, b_x_q};
   assign by1 = {1'b0, b_y_q};

   assign sprite_on = (vx1 >= bx1) && (vx1 <= bx1 + W_M1) &&
                      (vy1 >= by1) && (vy1 <= by1 + H_M1);
   assign col    = v_x - b_x_q;
   assign row    = v_y - b_y_q;
   assign b_x    = b_x_q;
   assign b_y    = b_y_q;
   assign facing = facing_q;
   assign moving = moving_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb/tb_sprite_motion_ctrl.sv - randomized bench for sprite_motion_ctrl against a behavioural model
module tb_sprite_motion_ctrl;

   localparam int P_STEP  = 2;
   localparam int P_MAXX  = 200;
   localparam int P_MAXY  = 440;
   localparam int P_MINX  = 0;
   localparam int P_MINY  = 16;
   localparam int P_SPR   = 16;
   localparam int P_GRID  = 16;
   localparam int P_SX    = 144;
   localparam int P_SY    = 400;
   localparam int P_ALIGN = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       L = 1'b0, R = 1'b0, U = 1'b0, D = 1'b0;
   logic [3:0] blocked = 4'b0;
   logic       game_over = 1'b0;
   logic [9:0] v_x = '0, v_y = '0;
   logic [9:0] b_x, b_y, col, row;
   logic       sprite_on, moving;
   logic [1:0] facing;

   int checks = 0;
   int failures = 0;

   // Model: position, activity (0 idle, 1 move, 2 glide), facing, cycles spent active.
   int m_x, m_y, m_mode, m_face, m_act;

   sprite_motion_ctrl #(
      .STEP_DIV(P_STEP), .MAX_X(P_MAXX), .MAX_Y(P_MAXY)
   ) dut (
      .clk(clk), .reset(reset), .L(L), .R(R), .U(U), .D(D),
      .blocked(blocked), .game_over(game_over), .v_x(v_x), .v_y(v_y),
      .b_x(b_x), .b_y(b_y), .col(col), .row(row),
      .sprite_on(sprite_on), .facing(facing), .moving(moving)
   );

   always #5 clk = ~clk;

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_x = P_SX; m_y = P_SY; m_mode = 0; m_face = 3; m_act = 0;
   endtask

   function automatic bit in_field(input int x, input int y);
      return x >= P_MINX && x <= P_MAXX - P_SPR && y >= P_MINY && y <= P_MAXY - P_SPR;
   endfunction

   function automatic bit req_of(input int dir);
      case (dir)
         0: return L;
         1: return R;
         2: return U;
         default: return D;
      endcase
   endfunction

   task automatic model_update();
      int  dx, dy, nx, ny, nmode;
      bit  held, tick, ok;
      dx = (m_face == 0) ? -1 : (m_face == 1) ? 1 : 0;
      dy = (m_face == 2) ? -1 : (m_face == 3) ? 1 : 0;
      nx = m_x + dx;
      ny = m_y + dy;
      held = req_of(m_face);
      tick = (m_mode != 0) && ((m_act % P_STEP) == P_STEP - 1);
      ok = in_field(nx, ny) && !blocked[3 - m_face];
      nmode = m_mode;
      if (game_over) nmode = 0;
      else if (m_mode == 0) begin
         if (L || R || U || D) begin
            m_face = L ? 0 : R ? 1 : U ? 2 : 3;
            nmode = 1;
         end
      end else if (m_mode == 1) begin
         if (held) begin
            if (tick && ok) begin m_x = nx; m_y = ny; end
         end else begin
            nmode = (P_ALIGN != 0 && (((m_face < 2) ? m_x : m_y) % P_GRID) != 0) ? 2 : 0;
         end
      end else begin
         if (held) nmode = 1;
         else if (tick) begin
            if (ok) begin
               m_x = nx; m_y = ny;
               if ((((m_face < 2) ? m_x : m_y) % P_GRID) == 0) nmode = 0;
            end else nmode = 0;
         end
      end
      m_act = (nmode == 0 || m_mode == 0) ? 0 : m_act + 1;
      m_mode = nmode;
   endtask

   task automatic check_all();
      int  vx, vy;
      bit  on;
      vx = int'(v_x);
      vy = int'(v_y);
      on = vx >= m_x && vx <= m_x + P_SPR - 1 && vy >= m_y && vy <= m_y + P_SPR - 1;
      expect_eq("b_x", b_x, m_x);
      expect_eq("b_y", b_y, m_y);
      expect_eq("facing", facing, m_face);
      expect_eq("moving", moving, m_mode != 0);
      expect_eq("sprite_on", sprite_on, on);
      expect_eq("col", col, (vx - m_x) & 1023);
      expect_eq("row", row, (vy - m_y) & 1023);
   endtask

   task automatic step_cycle();
      if ($urandom_range(0, 1) != 0) v_x = 10'($urandom_range(0, 1023));
      else                           v_x = 10'(m_x - 2 + int'($urandom_range(0, 20)));
      if ($urandom_range(0, 1) != 0) v_y = 10'($urandom_range(0, 1023));
      else                           v_y = 10'(m_y - 2 + int'($urandom_range(0, 20)));
      model_update();
      @(negedge clk);
      check_all();
   endtask

   task automatic set_dirs(input bit l, input bit r, input bit u, input bit d);
      L = l; R = r; U = u; D = d;
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      expect_eq("rst_bx", b_x, 144);
      expect_eq("rst_by", b_y, 400);
      expect_eq("rst_face", facing, 3);
      expect_eq("rst_moving", moving, 0);

      for (int v = 143; v <= 160; v++) begin
         v_x = 10'(v);
         v_y = 10'd400;
         #1;
         expect_eq("sweep_on", sprite_on, (v >= 144 && v <= 159));
         if (v == 144) expect_eq("sweep_col0", col, 0);
      end

      @(negedge clk);
      reset = 1'b1;

      // Enter a glide, then pull reset between clock edges.
      set_dirs(0, 1, 0, 0);
      repeat (3) step_cycle();
      set_dirs(0, 0, 0, 0);
      repeat (2) step_cycle();
      expect_eq("in_glide", moving, 1);
      #2 reset = 1'b0;
      #1;
      expect_eq("arst_bx", b_x, 144);
      expect_eq("arst_by", b_y, 400);
      expect_eq("arst_face", facing, 3);
      expect_eq("arst_moving", moving, 0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;

      set_dirs(1, 0, 1, 0);
      step_cycle();
      expect_eq("prio_face", facing, 0);
      set_dirs(1, 0, 0, 0);
      repeat (5) step_cycle();
      set_dirs(0, 0, 0, 0);
      repeat (40) step_cycle();
      expect_eq("glide_x", b_x, 128);
      expect_eq("glide_done", moving, 0);

      set_dirs(1, 0, 0, 0);
      repeat (300) step_cycle();
      expect_eq("clamp_x0", b_x, 0);
      expect_eq("clamp_moving", moving, 1);
      set_dirs(0, 0, 0, 0);
      step_cycle();
      set_dirs(0, 0, 1, 0);
      repeat (800) step_cycle();
      expect_eq("clamp_y16", b_y, 16);
      expect_eq("clamp_x_keep", b_x, 0);
      set_dirs(0, 0, 0, 0);
      step_cycle();

      set_dirs(0, 0, 0, 1);
      blocked = 4'b0001;
      repeat (8) step_cycle();
      expect_eq("blk_hold", b_y, 16);
      blocked = 4'b0000;
      repeat (4) step_cycle();
      expect_eq("blk_release", b_y, 18);
      game_over = 1'b1;
      step_cycle();
      expect_eq("go_idle", moving, 0);
      repeat (3) step_cycle();
      expect_eq("go_freeze", b_y, 18);
      game_over = 1'b0;
      set_dirs(0, 0, 0, 0);
      step_cycle();

      repeat (200) begin
         int sel, len;
         sel = int'($urandom_range(0, 9));
         len = int'($urandom_range(1, 40));
         if (sel < 4)       set_dirs(sel == 0, sel == 1, sel == 2, sel == 3);
         else if (sel == 4) set_dirs($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                                     $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
         else               set_dirs(0, 0, 0, 0);
         for (int i = 0; i < len; i++) begin
            blocked   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            game_over = ($urandom_range(0, 63) == 0);
            step_cycle();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
